// File: rtl/lzc_seq.sv
// Sequential leading-ones counter: scans a W-bit word MSB first, C bits per cycle,
// through one shared C-bit LZD.
module lzd #(
  parameter int C  = 64,
  parameter int LW = $clog2(C)
) (
  input  logic [C-1:0]  data,
  output logic [LW-1:0] cnt,
  output logic          vld
);
  // vld marks the first 0 from the MSB; cnt is the number of 1s above it
  always_comb begin
    cnt = '0;
    vld = 1'b0;
    for (int i = C - 1; i >= 0; i--) begin
      if (!vld && !data[i]) begin
        vld = 1'b1;
        cnt = LW'(C - 1 - i);
      end
    end
  end
endmodule

module lzc_seq #(
  parameter int W  = 256,
  parameter int C  = 64,
  parameter int CW = $clog2(W) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_count,
  output logic          out_all_ones,
  output logic          busy
);
  localparam int N  = W / C;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = $clog2(C);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  data_q, data_d;
  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          all_q, all_d;

  logic [W-1:0]  shifted;
  logic [C-1:0]  chunk;
  logic [LW-1:0] lzd_cnt;
  logic          lzd_vld;

  assign shifted = data_q << (int'(k_q) * C);
  assign chunk   = shifted[W-1 -: C];

  lzd #(.C(C), .LW(LW)) u_lzd (
    .data (chunk),
    .cnt  (lzd_cnt),
    .vld  (lzd_vld)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    k_d     = k_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    all_d   = all_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          k_d     = '0;
          acc_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (lzd_vld) begin
          cnt_d   = acc_q + {{(CW-LW){1'b0}}, lzd_cnt};
          all_d   = 1'b0;
          state_d = DONE;
        end else if (k_q == KW'(N - 1)) begin
          cnt_d   = CW'(W);
          all_d   = 1'b1;
          state_d = DONE;
        end else begin
          acc_d = acc_q + CW'(C);
          k_d   = k_q + KW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      all_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      all_q   <= all_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign out_count    = cnt_q;
  assign out_all_ones = all_q;
endmodule

// File: tb/tb_lzc_seq.sv
// Directed and random checks of lzc_seq against a bit-counting reference model.
module tb_lzc_seq;
  localparam int W  = 256;
  localparam int C  = 64;
  localparam int CW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          rst, in_valid, out_ready;
  logic [W-1:0]  in_data;
  logic          in_ready, out_valid, out_all_ones, busy;
  logic [CW-1:0] out_count;

  int n_vec = 0;
  int n_bad = 0;

  lzc_seq #(.W(W), .C(C)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_count    (out_count),
    .out_all_ones (out_all_ones),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_count(input logic [W-1:0] d);
    int n = 0;
    while (n < W && d[W-1-n]) n++;
    return n;
  endfunction

  function automatic int ref_lat(input int n);
    return (n >= W) ? W / C : n / C + 1;
  endfunction

  function automatic logic [W-1:0] make_word(input int n);
    logic [W-1:0] w;
    for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom;
    for (int i = 0; i < n; i++) w[W-1-i] = 1'b1;
    if (n < W) w[W-1-n] = 1'b0;
    return w;
  endfunction

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_job(input string tag, input logic [W-1:0] d);
    int lat, n;
    n = ref_count(d);
    chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(ref_lat(n)));
    chk({tag, "_cnt"}, 64'(out_count), 64'(n));
    chk({tag, "_all"}, 64'(out_all_ones), 64'(n == W));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [W-1:0] w, w2;
    int lat;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; in_data = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_cnt", 64'(out_count), 64'd0);
    chk("rst_all", 64'(out_all_ones), 64'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    run_job("zero", '0);
    w = '1;
    w[W-101] = 1'b0;
    run_job("c100", w);
    run_job("ones", '1);

    // hold result under backpressure while in_valid toggles
    w = make_word(130);
    in_valid = 1'b1;
    in_data = w;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    chk("hold_lat", 64'(lat), 64'(ref_lat(130)));
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data = '0;
      @(negedge clk);
      chk("hold_cnt", 64'(out_count), 64'd130);
      chk("hold_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold_rel", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("hold_noacc", 64'(busy), 64'd0);

    // reset mid-scan discards the job
    in_valid = 1'b1;
    in_data = '1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_valid", 64'(out_valid), 64'd0);
    chk("mid_ready", 64'(in_ready), 64'd1);
    w = '1;
    w[191] = 1'b0;
    run_job("c64", w);

    // back-to-back jobs with in_valid and out_ready held high
    w  = make_word(70);
    w2 = make_word(200);
    in_data = w;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("b2b_acc1", 64'(busy), 64'd1);
    wait_valid(lat);
    chk("b2b_lat1", 64'(lat), 64'(ref_lat(70)));
    chk("b2b_cnt1", 64'(out_count), 64'd70);
    in_data = w2;
    @(negedge clk);
    chk("b2b_gap", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("b2b_acc2", 64'(busy), 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b0;
    wait_valid(lat);
    chk("b2b_lat2", 64'(lat), 64'(ref_lat(200)));
    chk("b2b_cnt2", 64'(out_count), 64'd200);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    for (int t = 0; t < 40; t++) begin
      int n;
      n = (t < 6) ? t * 64 - ((t > 0) ? 1 : 0) : int'($urandom_range(0, W));
      if (n < 0) n = 0;
      if (n > W) n = W;
      run_job("rnd", make_word(n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
